pixel_stream_sink: RTL and testbench

//  Consumer end of the coordinate-stream interface driven by our generator modules (e.g. rectangle_filled).

---
 rtl/pixel_sink_pkg.sv | 14 +
 rtl/pixel_fb_mem.sv | 47 ++++
 rtl/pixel_stream_sink.sv | 115 +++++++++++
 tb/tb_pixel_stream_sink.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/pixel_sink_pkg.sv
// Shared types and constants for the pixel stream sink.
package pixel_sink_pkg;

  typedef enum logic [1:0] {CLEAR, COLLECT, DONE} state_e;

  localparam int unsigned CLIP_W = 16;
  localparam logic [CLIP_W-1:0] CLIP_MAX = 16'hFFFF;

  // Counter wide enough to hold every pixel of the bitmap being set.
  function automatic int unsigned cnt_w(input int unsigned w, input int unsigned h);
    return $clog2(w * h + 1);
  endfunction

endpackage

// File: rtl/pixel_fb_mem.sv
// HEIGHT x WIDTH bit array: row-clear port, bit-set port with prior value, registered row read.
module pixel_fb_mem #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned HEIGHT = 16,
  localparam int unsigned XW = $clog2(WIDTH),
  localparam int unsigned YW = $clog2(HEIGHT)
) (
  input  logic             _clock,
  input  logic             _start,
  input  logic             clr_en,
  input  logic [YW-1:0]    clr_row,
  input  logic             set_en,
  input  logic [YW-1:0]    set_row,
  input  logic [XW-1:0]    set_col,
  output logic             set_prior,
  input  logic [YW-1:0]    rd_row,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] bits [HEIGHT];
  logic             rd_in_range;

  assign set_prior = bits[set_row][set_col];

  if (HEIGHT == (1 << YW)) begin : g_full
    assign rd_in_range = 1'b1;
  end else begin : g_partial
    assign rd_in_range = (32'(rd_row) < HEIGHT);
  end

  always_ff @(posedge _clock) begin
    if (clr_en) bits[clr_row] <= '0;
    if (set_en) bits[set_row][set_col] <= 1'b1;
  end

  // Reads sample the array before this cycle's writes land.
  always_ff @(posedge _clock) begin
    if (_start) begin
      rd_data <= '0;
    end else if (rd_in_range) begin
      rd_data <= bits[rd_row];
    end else begin
      rd_data <= '0;
    end
  end

endmodule

// File: rtl/pixel_stream_sink.sv
// Coordinate-stream consumer: clips (x,y) to a bitmap, counts unique/clipped pixels, tracks bbox.
module pixel_stream_sink
  import pixel_sink_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned HEIGHT     = 16,
  localparam int unsigned CNT_W = cnt_w(WIDTH, HEIGHT),
  localparam int unsigned XW    = $clog2(WIDTH),
  localparam int unsigned YW    = $clog2(HEIGHT)
) (
  input  logic                  _clock,
  input  logic                  _start,
  input  logic [DATA_WIDTH-1:0] _in0,
  input  logic [DATA_WIDTH-1:0] _in1,
  input  logic                  _valid,
  input  logic                  _in_done,
  output logic                  _ready,
  output logic                  _done,
  output logic [CNT_W-1:0]      pixel_count,
  output logic [CLIP_W-1:0]     clip_count,
  output logic                  bbox_valid,
  output logic [XW-1:0]         min_x,
  output logic [XW-1:0]         max_x,
  output logic [YW-1:0]         min_y,
  output logic [YW-1:0]         max_y,
  input  logic [YW-1:0]         rd_row,
  output logic [WIDTH-1:0]      rd_data
);

  state_e        state;
  logic [YW-1:0] row_ptr;
  logic          xfer, in_range, prior;
  logic [XW-1:0] px;
  logic [YW-1:0] py;

  // Sign bit clear plus unsigned upper bound gives the signed 0 <= v < N test.
  assign in_range = !_in0[DATA_WIDTH-1] && (_in0 < DATA_WIDTH'(WIDTH)) &&
                    !_in1[DATA_WIDTH-1] && (_in1 < DATA_WIDTH'(HEIGHT));
  assign xfer     = _valid && _ready && (state == COLLECT);
  assign px       = _in0[XW-1:0];
  assign py       = _in1[YW-1:0];

  pixel_fb_mem #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) u_mem (
    ._clock    (_clock),
    ._start    (_start),
    .clr_en    (state == CLEAR),
    .clr_row   (row_ptr),
    .set_en    (xfer && in_range),
    .set_row   (py),
    .set_col   (px),
    .set_prior (prior),
    .rd_row    (rd_row),
    .rd_data   (rd_data)
  );

  always_ff @(posedge _clock) begin
    if (_start) begin
      state       <= CLEAR;
      row_ptr     <= '0;
      _ready      <= 1'b0;
      _done       <= 1'b0;
      pixel_count <= '0;
      clip_count  <= '0;
      bbox_valid  <= 1'b0;
      min_x       <= '0;
      max_x       <= '0;
      min_y       <= '0;
      max_y       <= '0;
    end else begin
      unique case (state)
        CLEAR: begin
          row_ptr <= row_ptr + 1'b1;
          if (row_ptr == YW'(HEIGHT - 1)) begin
            row_ptr <= '0;
            state   <= COLLECT;
            _ready  <= 1'b1;
          end
        end
        COLLECT: begin
          if (xfer) begin
            if (in_range) begin
              if (!prior) pixel_count <= pixel_count + 1'b1;
              bbox_valid <= 1'b1;
              if (!bbox_valid) begin
                min_x <= px;
                max_x <= px;
                min_y <= py;
                max_y <= py;
              end else begin
                if (px < min_x) min_x <= px;
                if (px > max_x) max_x <= px;
                if (py < min_y) min_y <= py;
                if (py > max_y) max_y <= py;
              end
            end else if (clip_count != CLIP_MAX) begin
              clip_count <= clip_count + 1'b1;
            end
          end
          if (_in_done) begin
            state  <= DONE;
            _ready <= 1'b0;
            _done  <= 1'b1;
          end
        end
        DONE: ;
        default: state <= CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_stream_sink.sv
// Directed self-checking bench for pixel_stream_sink.
module tb_pixel_stream_sink;

  logic        clk = 1'b0;
  logic        start, valid, in_done;
  logic [31:0] in0, in1;
  logic        ready, done, bbox_valid;
  logic [8:0]  pixel_count;
  logic [15:0] clip_count;
  logic [3:0]  min_x, max_x, min_y, max_y, rd_row;
  logic [15:0] rd_data;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  pixel_stream_sink dut (
    ._clock      (clk),
    ._start      (start),
    ._in0        (in0),
    ._in1        (in1),
    ._valid      (valid),
    ._in_done    (in_done),
    ._ready      (ready),
    ._done       (done),
    .pixel_count (pixel_count),
    .clip_count  (clip_count),
    .bbox_valid  (bbox_valid),
    .min_x       (min_x),
    .max_x       (max_x),
    .min_y       (min_y),
    .max_y       (max_y),
    .rd_row      (rd_row),
    .rd_data     (rd_data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse start, then require _ready to rise exactly 16 cycles later.
  task automatic restart();
    int n;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!ready && n < 100) begin
      tick();
      n++;
    end
    check("clear_len", n, 16);
  endtask

  task automatic send(input int x, input int y);
    in0   = x;
    in1   = y;
    valid = 1'b1;
    tick();
    valid = 1'b0;
  endtask

  task automatic close();
    in_done = 1'b1;
    tick();
    in_done = 1'b0;
    check("done_hi", done, 1);
    check("ready_lo", ready, 0);
  endtask

  task automatic check_row(input string tag, input int r, input logic [15:0] exp);
    rd_row = 4'(r);
    tick();
    check(tag, rd_data, exp);
  endtask

  initial begin
    start = 1'b1; valid = 1'b0; in_done = 1'b0; in0 = '0; in1 = '0; rd_row = '0;
    tick();
    tick();
    check("rst_ready", ready, 0);
    check("rst_done", done, 0);
    check("rst_pix", pixel_count, 0);
    check("rst_clip", clip_count, 0);
    check("rst_bbox", bbox_valid, 0);
    check("rst_rd", rd_data, 0);

    // 1: filled rectangle, columns 2..5, rows 3..7
    restart();
    for (int y = 3; y <= 7; y++)
      for (int x = 2; x <= 5; x++)
        send(x, y);
    close();
    check("t1_pix", pixel_count, 20);
    check("t1_clip", clip_count, 0);
    check("t1_bbv", bbox_valid, 1);
    check("t1_minx", min_x, 2);
    check("t1_maxx", max_x, 5);
    check("t1_miny", min_y, 3);
    check("t1_maxy", max_y, 7);
    for (int r = 0; r < 16; r++)
      check_row("t1_row", r, (r >= 3 && r <= 7) ? 16'h003C : 16'h0000);

    // 2: same pixel three cycles back to back
    restart();
    in0 = 1; in1 = 1; valid = 1'b1;
    tick(); tick(); tick();
    valid = 1'b0;
    close();
    check("t2_pix", pixel_count, 1);
    check_row("t2_row1", 1, 16'h0002);
    check("t2_done", done, 1);

    // 3: all clipped
    restart();
    send(-1, 0);
    send(16, 0);
    send(0, 16);
    close();
    check("t3_pix", pixel_count, 0);
    check("t3_clip", clip_count, 3);
    check("t3_bbv", bbox_valid, 0);
    check_row("t3_row0", 0, 16'h0000);

    // 4: restart in the middle of collection
    restart();
    for (int i = 0; i < 5; i++) send(i, 0);
    check("t4_pre", pixel_count, 5);
    restart();
    for (int r = 0; r < 16; r++) check_row("t4_row", r, 16'h0000);
    check("t4_pix", pixel_count, 0);
    check("t4_clip", clip_count, 0);
    check("t4_bbv", bbox_valid, 0);

    // 5: transfer and done in the same cycle
    in0 = 4; in1 = 4; valid = 1'b1; in_done = 1'b1;
    tick();
    valid = 1'b0; in_done = 1'b0;
    check("t5_done", done, 1);
    check("t5_ready", ready, 0);
    check("t5_pix", pixel_count, 1);
    check("t5_minx", min_x, 4);
    in0 = 5; in1 = 5; valid = 1'b1;
    tick(); tick(); tick();
    valid = 1'b0;
    check("t5_pix_after", pixel_count, 1);
    check("t5_maxx", max_x, 4);
    check_row("t5_row4", 4, 16'h0010);
    check_row("t5_row5", 5, 16'h0000);

    // 6: valid held through CLEAR
    in0 = 0; in1 = 0; valid = 1'b1;
    restart();
    check("t6_pix_pre", pixel_count, 0);
    tick();
    valid = 1'b0;
    tick();
    check("t6_pix", pixel_count, 1);
    check("t6_clip", clip_count, 0);
    check_row("t6_row0", 0, 16'h0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
